// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth signed multiplier, one Booth step per clock
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t nxt;
  state_t state;
  logic [WIDTH:0] a;
  logic [WIDTH:0] mx;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] an;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic qm1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state == IDLE ? (start ? RUN : IDLE) :
          state == RUN  ? (cnt == CW'(1) ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE;
    // mx is one bit wider than the operand so negating -2^(WIDTH-1) cannot overflow
    sum = {q[0], qm1} == 2'b10 ? a - mx :
          {q[0], qm1} == 2'b01 ? a + mx : a;
    an = {sum[WIDTH], sum[WIDTH:1]};
    qn = {sum[0], q[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a       <= '0;
      q       <= '0;
      qm1     <= 1'b0;
      mx      <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (state == IDLE && start) begin
      a   <= '0;
      q   <= mplier;
      qm1 <= 1'b0;
      mx  <= {mcand[WIDTH-1], mcand};
      cnt <= CW'(WIDTH);
    end else if (state == RUN) begin
      a   <= an;
      q   <= qn;
      qm1 <= q[0];
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) product <= {an[WIDTH-1:0], qn};
    end
  end
endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: scoreboard bench; stimulus queues expected products, monitor checks on done
module tb_booth_seq_mult;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] mcand = '0;
  logic [W-1:0] mplier = '0;
  logic busy;
  logic done;
  logic [2*W-1:0] product;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] last_exp = '0;
  logic mon_on = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] r;
    r = $signed(x) * $signed(y);
    return r;
  endfunction

  // Monitor: samples 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      if (rst) begin
        last_exp = '0;
        chk("reset_product", product, 0);
      end else if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          last_exp = sb.pop_front();
          chk("product", product, last_exp);
        end
      end else chk("product_hold", product, last_exp);
    end
  end

  task automatic mult(input logic [W-1:0] mc, input logic [W-1:0] mp, input logic [2*W-1:0] exp);
    int bc;
    @(negedge clk);
    mcand = mc;
    mplier = mp;
    start = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    mcand = ~mc;
    mplier = ~mp;
    bc = 0;
    for (int i = 0; i < W; i++) begin
      if (busy) bc++;
      chk("no_early_done", done, 0);
      @(negedge clk);
    end
    chk("busy_cycles", bc, W);
    chk("done_latency", done, 1);
    chk("busy_in_done", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    logic [W-1:0] a0, b0, a1, b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_prod", product, 0);

    mult(8'd7, 8'd3, 16'h0015);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    mult(8'hFB, 8'd7, 16'hFFDD);
    mult(8'd127, 8'h80, 16'hC080);
    mult(8'h80, 8'h80, 16'h4000);
    mult(8'h00, 8'h80, 16'h0000);
    mult(8'hFF, 8'hFF, 16'h0001);
    mult(8'h01, 8'h80, 16'hFF80);
    mult(8'h80, 8'h7F, 16'hC080);
    @(negedge clk);

    // start held high with operands changing every cycle
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      mcand = 8'(i * 37 + 11);
      mplier = 8'(100 - i * 23);
      start = 1'b1;
      if (i == 0 || i == 10) sb.push_back(ref_mul(mcand, mplier));
      @(negedge clk);
      if (done) dn++;
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("held_start_dones", dn, 2);

    // reset during step 4
    @(negedge clk);
    mcand = 8'd9;
    mplier = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_prod", product, 0);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
    mult(8'hF6, 8'd12, 16'hFF88);

    for (int i = 0; i < 1000; i++) begin
      a1 = 8'($urandom);
      b1 = 8'($urandom);
      mult(a1, b1, ref_mul(a1, b1));
    end
    a0 = 8'h80;
    b0 = 8'h01;
    mult(a0, b0, 16'hFF80);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
